bloco_vida: RTL and testbench

Parametrised brick for the Breakout playfield. It is the successor of the single-hit brick and adds:
- a configurable hit-point count
- an internal descent timer with a configurable period
- registered, side-encoded hit reporting with contact debounce, so one ball contact costs exactly one hit point
- a destruction pulse for the score logic

One instance sits per brick between the ball controller (consumes `hit`/`hit_side`) and the VGA renderer (consumes `area`/`exist`/`lives`).

---
 rtl/bloco_vida_pkg.sv | 37 +++
 rtl/bloco_vida_tick_gen.sv | 28 ++
 rtl/bloco_vida.sv | 157 +++++++++++++++
 tb/tb_bloco_vida.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bloco_vida_pkg.sv
// Shared types and defaults for the Breakout brick: FSM states, contact side
// bit positions and the default playfield geometry.
package bloco_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACTIVE  = 3'd1,
      CONTACT = 3'd2,
      DEAD    = 3'd3,
      OVER    = 3'd4
   } state_t;

   localparam int SIDE_U = 3;
   localparam int SIDE_D = 2;
   localparam int SIDE_L = 1;
   localparam int SIDE_R = 0;

   localparam int R_BALL_D      = 8;
   localparam int H_BLOCK_D     = 16;
   localparam int W_BLOCK_D     = 64;
   localparam int V_BLOCK_D     = 2;
   localparam int MOVE_PERIOD_D = 1_000_000;
   localparam int HITS_D        = 3;
   localparam int Y_LIMIT_D     = 454;

   // Screen coordinates widened to signed 12 bits so edges near 0 go negative.
   function automatic logic signed [11:0] sx(input logic [9:0] v);
      return signed'({2'b00, v});
   endfunction

   function automatic logic in_rng(input logic signed [11:0] v,
                                   input logic signed [11:0] lo,
                                   input logic signed [11:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/bloco_vida_tick_gen.sv
// Free-running period counter that pauses while disabled; emits a one-cycle
// tick every PERIOD enabled cycles.
module tick_gen #(
   parameter int PERIOD = 1_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(PERIOD);
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/bloco_vida.sv
// Breakout brick: hit points, timed descent, debounced side-encoded hit
// reporting and a destruction pulse for scoring.
module bloco_vida
   import bloco_pkg::*;
#(
   parameter int R_BALL      = R_BALL_D,
   parameter int H_BLOCK     = H_BLOCK_D,
   parameter int W_BLOCK     = W_BLOCK_D,
   parameter int V_BLOCK     = V_BLOCK_D,
   parameter int MOVE_PERIOD = MOVE_PERIOD_D,
   parameter int HITS        = HITS_D,
   parameter int Y_LIMIT     = Y_LIMIT_D
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       endgame,
   input  logic       hit_lava,
   input  logic [9:0] x_i,
   input  logic [9:0] y_i,
   input  logic [9:0] x_ball,
   input  logic [9:0] y_ball,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   output logic       area,
   output logic       hit,
   output logic [3:0] hit_side,
   output logic       destroyed,
   output logic       endgame_block,
   output logic       exist,
   output logic [3:0] lives
);

   localparam logic signed [11:0] RS  = R_BALL[11:0];
   localparam logic signed [11:0] HS  = H_BLOCK[11:0];
   localparam logic signed [11:0] WS  = W_BLOCK[11:0];
   localparam logic signed [11:0] TWO = 12'sd2;
   localparam logic [10:0]        VS  = V_BLOCK[10:0];
   localparam logic [9:0]         YL  = Y_LIMIT[9:0];

   state_t     state, state_nx;
   logic [9:0] x_block, y_block;
   logic       tick, run;

   logic signed [11:0] xs, ys, xbs, ybs, pxs, pys;
   logic [3:0]         zones;
   logic               contact;
   logic [10:0]        y_sum;
   logic [9:0]         y_down;

   logic       hit_nx, destr_nx, exist_nx;
   logic [3:0] side_nx, lives_nx;

   assign xs  = sx(x_block);
   assign ys  = sx(y_block);
   assign xbs = sx(x_ball);
   assign ybs = sx(y_ball);
   assign pxs = sx(pix_x);
   assign pys = sx(pix_y);

   // Each zone is a band just outside one face, trimmed 2 px at the corners.
   assign zones[SIDE_U] = in_rng(ybs, ys - HS - RS + TWO, ys - HS + TWO)
                       && in_rng(xbs, xs - WS + TWO, xs + WS - TWO);
   assign zones[SIDE_D] = in_rng(ybs, ys + HS - TWO, ys + HS + RS - TWO)
                       && in_rng(xbs, xs - WS + TWO, xs + WS - TWO);
   assign zones[SIDE_L] = in_rng(xbs, xs - WS - RS + TWO, xs - WS + TWO)
                       && in_rng(ybs, ys - HS + TWO, ys + HS - TWO);
   assign zones[SIDE_R] = in_rng(xbs, xs + WS - TWO, xs + WS + RS - TWO)
                       && in_rng(ybs, ys - HS + TWO, ys + HS - TWO);

   assign contact = exist && (zones != 4'b0000);

   assign area = in_rng(pxs, xs - WS, xs + WS) && in_rng(pys, ys - HS, ys + HS);
   assign endgame_block = exist && (y_block >= YL);

   assign y_sum  = {1'b0, y_block} + VS;
   assign y_down = y_sum[10] ? 10'd1023 : y_sum[9:0];

   assign run = (state == ACTIVE) || (state == CONTACT);

   tick_gen #(.PERIOD(MOVE_PERIOD)) u_tick (
      .clock (clock),
      .reset (reset),
      .en    (run),
      .tick  (tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      hit_nx   = 1'b0;
      side_nx  = 4'b0000;
      destr_nx = 1'b0;
      lives_nx = lives;
      exist_nx = exist;
      unique case (state)
         IDLE: begin
            if (endgame)    state_nx = OVER;
            else if (start) state_nx = ACTIVE;
         end
         ACTIVE: begin
            if (endgame)       state_nx = OVER;
            else if (hit_lava) state_nx = IDLE;
            else if (contact) begin
               hit_nx   = 1'b1;
               side_nx  = zones;
               lives_nx = lives - 4'd1;
               if (lives == 4'd1) begin
                  exist_nx = 1'b0;
                  destr_nx = 1'b1;
                  state_nx = DEAD;
               end else begin
                  state_nx = CONTACT;
               end
            end
         end
         // Debounce: stay here until the ball has left every zone.
         CONTACT: begin
            if (endgame)               state_nx = OVER;
            else if (hit_lava)         state_nx = IDLE;
            else if (zones == 4'b0000) state_nx = ACTIVE;
         end
         DEAD: begin
            exist_nx = 1'b0;
            if (endgame) state_nx = OVER;
         end
         OVER:    state_nx = OVER;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_block   <= x_i;
         y_block   <= y_i;
         lives     <= 4'(HITS);
         exist     <= 1'b1;
         hit       <= 1'b0;
         hit_side  <= 4'b0000;
         destroyed <= 1'b0;
      end else begin
         if (tick) y_block <= y_down;
         lives     <= lives_nx;
         exist     <= exist_nx;
         hit       <= hit_nx;
         hit_side  <= side_nx;
         destroyed <= destr_nx;
      end
   end

endmodule

// File: tb/tb_bloco_vida.sv
// Scoreboard bench for bloco_vida: reference model pushes expected hits,
// a negedge monitor pops and compares them and checks the visible state.
module tb_bloco_vida;

   localparam int P = 4, HITS = 2, R = 8, H = 16, W = 64, V = 2, YL = 454;
   localparam int M_IDLE = 0, M_RUN = 1, M_TOUCH = 2, M_DEAD = 3, M_OVER = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, endgame = 1'b0, hit_lava = 1'b0;
   logic [9:0] x_i = 10'd320, y_i = 10'd100;
   logic [9:0] x_ball = '0, y_ball = '0, pix_x = '0, pix_y = '0;
   logic       area, hit, destroyed, endgame_block, exist;
   logic [3:0] hit_side, lives;

   always #5 clock = ~clock;

   bloco_vida #(
      .R_BALL(R), .H_BLOCK(H), .W_BLOCK(W), .V_BLOCK(V),
      .MOVE_PERIOD(P), .HITS(HITS), .Y_LIMIT(YL)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .endgame(endgame),
      .hit_lava(hit_lava), .x_i(x_i), .y_i(y_i), .x_ball(x_ball),
      .y_ball(y_ball), .pix_x(pix_x), .pix_y(pix_y), .area(area), .hit(hit),
      .hit_side(hit_side), .destroyed(destroyed),
      .endgame_block(endgame_block), .exist(exist), .lives(lives)
   );

   typedef struct {
      logic [3:0] side;
      int         lives;
      bit         destr;
      bit         exist;
   } exp_t;

   exp_t q[$];
   int   m_x, m_y, m_lives, m_mode, m_res;
   bit   m_exist;
   int   n_checks = 0, n_fail = 0, n_hits = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] zones_of(input int bx, input int by,
                                           input int x, input int y);
      bit inx, iny, u, d, l, r;
      inx = bx >= x - W + 2 && bx <= x + W - 2;
      iny = by >= y - H + 2 && by <= y + H - 2;
      u = inx && by >= y - H - R + 2 && by <= y - H + 2;
      d = inx && by >= y + H - 2 && by <= y + H + R - 2;
      l = iny && bx >= x - W - R + 2 && bx <= x - W + 2;
      r = iny && bx >= x + W - 2 && bx <= x + W + R - 2;
      return {u, d, l, r};
   endfunction

   function automatic logic [9:0] c10(input int v);
      return (v < 0) ? 10'd0 : (v > 1023) ? 10'd1023 : 10'(v);
   endfunction

   // Reference model: residency cycles counted in plain integers.
   always @(posedge clock or posedge reset) begin
      logic [3:0] z;
      bit         tk;
      if (reset) begin
         m_x = int'(x_i); m_y = int'(y_i); m_lives = HITS; m_exist = 1;
         m_mode = M_IDLE; m_res = 0; q.delete();
      end else begin
         z  = zones_of(int'(x_ball), int'(y_ball), m_x, m_y);
         tk = 0;
         if (m_mode == M_RUN || m_mode == M_TOUCH) begin
            m_res++;
            tk = (m_res % P) == 0;
         end
         case (m_mode)
            M_IDLE:  if (endgame) m_mode = M_OVER; else if (start) m_mode = M_RUN;
            M_RUN: begin
               if (endgame) m_mode = M_OVER;
               else if (hit_lava) m_mode = M_IDLE;
               else if (m_exist && z != 0) begin
                  m_lives--;
                  if (m_lives == 0) begin m_exist = 0; m_mode = M_DEAD; end
                  else m_mode = M_TOUCH;
                  q.push_back('{side: z, lives: m_lives, destr: !m_exist, exist: m_exist});
               end
            end
            M_TOUCH: if (endgame) m_mode = M_OVER; else if (hit_lava) m_mode = M_IDLE;
                     else if (z == 0) m_mode = M_RUN;
            M_DEAD:  if (endgame) m_mode = M_OVER;
            default: ;
         endcase
         if (tk) m_y = (m_y + V > 1023) ? 1023 : m_y + V;
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         chk("lives", int'(lives), m_lives);
         chk("exist", int'(exist), int'(m_exist));
         chk("endgame_block", int'(endgame_block), int'(m_exist && m_y >= YL));
         chk("area", int'(area), int'(int'(pix_x) >= m_x - W && int'(pix_x) <= m_x + W &&
                                      int'(pix_y) >= m_y - H && int'(pix_y) <= m_y + H));
         if (hit) begin
            n_hits++;
            if (q.size() == 0) chk("unexpected_hit", 1, 0);
            else begin
               e = q.pop_front();
               chk("hit_side", int'(hit_side), int'(e.side));
               chk("hit_lives", int'(lives), e.lives);
               chk("destroyed", int'(destroyed), int'(e.destr));
               chk("hit_exist", int'(exist), int'(e.exist));
            end
         end else begin
            chk("idle_side", int'(hit_side), 0);
            chk("idle_destroyed", int'(destroyed), 0);
            if (q.size() > 0) begin
               chk("missing_hit", 0, 1);
               void'(q.pop_front());
            end
         end
      end
   end

   // Scan pixel lands on or just outside a rectangle edge of the model brick.
   task automatic pick_pix();
      int dx[5] = '{-W - 1, -W, 0, W, W + 1};
      int dy[5] = '{-H - 1, -H, 0, H, H + 1};
      pix_x = c10(m_x + dx[$urandom_range(4)]);
      pix_y = c10(m_y + dy[$urandom_range(4)]);
   endtask

   task automatic cyc(input bit st, input bit eg, input bit lv, input int bx, input int by);
      start = st; endgame = eg; hit_lava = lv;
      x_ball = c10(bx); y_ball = c10(by);
      pick_pix();
      @(posedge clock); #1;
   endtask

   task automatic do_reset(input int xi, input int yi);
      start = 0; endgame = 0; hit_lava = 0;
      reset = 1; x_i = c10(xi); y_i = c10(yi);
      @(posedge clock); @(posedge clock); #1;
      reset = 0;
   endtask

   initial begin
      int h0;
      do_reset(320, 100);
      chk("rst_lives", int'(lives), HITS);
      chk("rst_exist", int'(exist), 1);
      chk("rst_hit", int'(hit), 0);
      chk("rst_side", int'(hit_side), 0);
      chk("rst_destroyed", int'(destroyed), 0);

      // descent with no contact
      repeat (13) cyc(1, 0, 0, 0, 0);
      // top contact held 5 cycles: one hit only
      h0 = n_hits;
      repeat (5) cyc(1, 0, 0, 320, m_y - 20);
      chk("single_hit", n_hits - h0, 1);
      repeat (3) cyc(1, 0, 0, 320, 200);
      // left contact kills the brick
      repeat (3) cyc(1, 0, 0, 250, m_y);
      chk("dead_lives", int'(lives), 0);
      repeat (10) cyc(1, 0, 0, 0, 0);

      // brick near origin, ball far corner
      do_reset(10, 10);
      h0 = n_hits;
      repeat (10) cyc(1, 0, 0, 600, 470);
      chk("no_wrap_hit", n_hits - h0, 0);

      // lava pause, then game over
      do_reset(320, 100);
      repeat (6) cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      repeat (6) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      h0 = n_hits;
      repeat (4) cyc(1, 0, 0, 320, m_y - 20);
      chk("over_no_hit", n_hits - h0, 0);
      do_reset(320, 452);
      repeat (6) cyc(1, 0, 0, 0, 0);
      chk("endgame_block", int'(endgame_block), 1);

      // asynchronous reset in CONTACT
      do_reset(320, 100);
      repeat (2) cyc(1, 0, 0, 0, 0);
      repeat (3) cyc(1, 0, 0, 320, m_y - 20);
      chk("pre_rst_lives", int'(lives), 1);
      reset = 1; #1;
      chk("async_lives", int'(lives), HITS);
      chk("async_exist", int'(exist), 1);
      chk("async_hit", int'(hit), 0);
      chk("async_side", int'(hit_side), 0);
      chk("async_destroyed", int'(destroyed), 0);
      @(posedge clock); #1; reset = 0;

      // randomized episodes
      for (int ep = 0; ep < 30; ep++) begin
         do_reset($urandom_range(639), $urandom_range(479));
         for (int c = 0; c < 40; c++)
            cyc($urandom_range(9) != 0, $urandom_range(79) == 0, $urandom_range(29) == 0,
                m_x + $urandom_range(160) - 80, m_y + $urandom_range(60) - 30);
      end
      cyc(0, 0, 0, 0, 0);
      chk("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
